// File: rtl/complement_pair_rx_if.sv
// Byte+complement link bundle: upstream valid/ready byte stream, downstream
// valid/ready verified-byte stream, and error status.
//   in_data/in_valid/in_ready     : link byte stream (receiver drives in_ready)
//   out_data/out_valid/out_ready  : verified byte stream (consumer drives out_ready)
//   err/err_code/err_count        : error pulse, last error code, saturating count
// slave = the receiver block, master = the surrounding logic / bench.
interface complement_pair_rx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] err_count;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, err, err_code, err_count
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err, err_code, err_count
  );
endinterface

// File: rtl/complement_pair_rx.sv
// Receiver for the byte+complement link. Each data byte arrives followed by
// its bitwise inverse; the pair is verified and the data byte forwarded.
// Mismatches and inter-byte timeouts pulse err, update err_code, bump the
// saturating err_count and drop the pair.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   link  : complement_pair_rx_if.slave (in_*/out_* streams, err status)
// Parameter:
//   TIMEOUT : idle cycles allowed while waiting for the complement (1..255)
module complement_pair_rx #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  complement_pair_rx_if.slave     link
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_COMP = 2'd1,
    HOLD      = 2'd2
  } state_t;

  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] first_q, first_n;
  logic [7:0] timer_q, timer_n;
  logic [7:0] od_q, od_n;
  logic       ov_q, ov_n;
  logic       err_q, err_n;
  logic [1:0] code_q, code_n;
  logic [7:0] cnt_q, cnt_n;
  logic [7:0] cnt_inc;

  // Stop at 255; later errors still pulse err and update err_code.
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      first_q <= '0;
      timer_q <= '0;
      od_q    <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      first_q <= first_n;
      timer_q <= timer_n;
      od_q    <= od_n;
      ov_q    <= ov_n;
      err_q   <= err_n;
      code_q  <= code_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    first_n = first_q;
    timer_n = timer_q;
    od_n    = od_q;
    ov_n    = ov_q;
    err_n   = 1'b0;
    code_n  = code_q;
    cnt_n   = cnt_q;
    case (state)
      IDLE: begin
        if (link.in_valid) begin
          first_n = link.in_data;
          timer_n = '0;
          state_n = WAIT_COMP;
        end
      end
      WAIT_COMP: begin
        // An accepted byte on the deadline cycle takes priority over timeout.
        if (link.in_valid) begin
          if (link.in_data == ~first_q) begin
            od_n    = first_q;
            ov_n    = 1'b1;
            state_n = HOLD;
          end else begin
            // Bad byte is dropped, not reused as the next first byte.
            err_n   = 1'b1;
            code_n  = 2'b01;
            cnt_n   = cnt_inc;
            state_n = IDLE;
          end
        end else if (timer_q == TLIM) begin
          err_n   = 1'b1;
          code_n  = 2'b10;
          cnt_n   = cnt_inc;
          state_n = IDLE;
        end else begin
          timer_n = timer_q + 8'd1;
        end
      end
      HOLD: begin
        if (link.out_ready) begin
          ov_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign link.in_ready  = (state != HOLD);
  assign link.out_data  = od_q;
  assign link.out_valid = ov_q;
  assign link.err       = err_q;
  assign link.err_code  = code_q;
  assign link.err_count = cnt_q;

endmodule
